// File: rtl/capture_sequencer.sv
// Command-driven measurement sequencer: transmit burst, settle gap, then a
// decimated two-channel capture streamed to the hex dumper.
module capture_sequencer #(
  parameter int TX_CYCLES     = 4800,
  parameter int SETTLE_CYCLES = 480,
  parameter int CAP_LEN       = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_dat,
  input  logic       cmd_stb,
  input  logic       sig,
  input  logic       sig1,
  input  logic       dump_ready,
  output logic       tx_en,
  output logic [1:0] sample,
  output logic       sample_stb,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic [7:0] overrun
);

  localparam int TICK_W = $clog2(CAP_LEN + 1);

  localparam logic [7:0] CMD_SINGLE = 8'h53;
  localparam logic [7:0] CMD_CONT   = 8'h43;
  localparam logic [7:0] CMD_ABORT  = 8'h58;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;
  logic [2:0]        decim_sel_q, decim_sel_d;
  logic [2:0]        decim_act_q, decim_act_d;
  logic              cont_q, cont_d;

  logic [1:0]        sample_d;
  logic [7:0]        overrun_d;
  logic              sample_stb_d, done_d, cmd_err_d, tx_en_d, busy_d;

  logic              is_abort, is_start, is_digit, start_ok;
  logic [CNT_W-1:0]  period_m1;

  assign is_abort  = cmd_stb && (cmd_dat == CMD_ABORT);
  assign is_start  = cmd_stb && ((cmd_dat == CMD_SINGLE) || (cmd_dat == CMD_CONT));
  assign is_digit  = cmd_stb && (cmd_dat[7:3] == 5'b00110);
  assign start_ok  = is_start && (state_q == ST_IDLE);
  assign period_m1 = (CNT_W'(1) << decim_act_q) - CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    ticks_d      = ticks_q;
    decim_sel_d  = decim_sel_q;
    decim_act_d  = decim_act_q;
    cont_d       = cont_q;
    sample_d     = sample;
    overrun_d    = overrun;
    sample_stb_d = 1'b0;
    cmd_err_d    = cmd_stb && !is_digit && !is_abort && !start_ok;

    if (is_digit) decim_sel_d = cmd_dat[2:0];

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_TX;
          cnt_d       = CNT_W'(TX_CYCLES - 1);
          decim_act_d = decim_sel_q;
          overrun_d   = 8'd0;
          cont_d      = (cmd_dat == CMD_CONT);
        end
      end
      ST_TX: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
          ticks_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        // One extra cycle after the last tick lets its strobe precede done.
        if (ticks_q == TICK_W'(CAP_LEN)) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          ticks_d = ticks_q + TICK_W'(1);
          cnt_d   = period_m1;
          if (dump_ready) begin
            sample_d     = {sig1, sig};
            sample_stb_d = 1'b1;
          end else if (overrun != 8'hFF) begin
            overrun_d = overrun + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (cont_q) begin
          state_d     = ST_TX;
          cnt_d       = CNT_W'(TX_CYCLES - 1);
          decim_act_d = decim_sel_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any tick or terminal count computed above.
    if (is_abort) begin
      state_d      = ST_IDLE;
      cont_d       = 1'b0;
      sample_d     = sample;
      sample_stb_d = 1'b0;
      overrun_d    = overrun;
    end

    tx_en_d = (state_d == ST_TX);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ticks_q     <= '0;
      decim_sel_q <= 3'd0;
      decim_act_q <= 3'd0;
      cont_q      <= 1'b0;
      tx_en       <= 1'b0;
      sample      <= 2'b00;
      sample_stb  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      overrun     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ticks_q     <= ticks_d;
      decim_sel_q <= decim_sel_d;
      decim_act_q <= decim_act_d;
      cont_q      <= cont_d;
      tx_en       <= tx_en_d;
      sample      <= sample_d;
      sample_stb  <= sample_stb_d;
      busy        <= busy_d;
      done        <= done_d;
      cmd_err     <= cmd_err_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with short burst/settle/capture lengths;
// a second instance with a long window exercises overrun saturation.
module tb_capture_sequencer;

  localparam int TX  = 10;
  localparam int ST  = 5;
  localparam int CAP = 8;
  localparam int C0  = TX + ST + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_dat = 8'h00;
  logic       cmd_stb = 1'b0;
  logic       sig = 1'b0, sig1 = 1'b0;
  logic       dump_ready = 1'b1;
  logic       tx_en, sample_stb, busy, done, cmd_err;
  logic [1:0] sample;
  logic [7:0] overrun;

  logic [7:0] cmd_dat_s = 8'h00;
  logic       cmd_stb_s = 1'b0;
  logic       sig_s = 1'b1, sig1_s = 1'b0, ready_s = 1'b0;
  logic       tx_en_s, sample_stb_s, busy_s, done_s, cmd_err_s;
  logic [1:0] sample_s;
  logic [7:0] overrun_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  capture_sequencer #(.TX_CYCLES(TX), .SETTLE_CYCLES(ST), .CAP_LEN(CAP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_dat(cmd_dat), .cmd_stb(cmd_stb), .sig(sig), .sig1(sig1),
    .dump_ready(dump_ready), .tx_en(tx_en), .sample(sample), .sample_stb(sample_stb),
    .busy(busy), .done(done), .cmd_err(cmd_err), .overrun(overrun)
  );

  capture_sequencer #(.TX_CYCLES(TX), .SETTLE_CYCLES(ST), .CAP_LEN(300), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .cmd_dat(cmd_dat_s), .cmd_stb(cmd_stb_s), .sig(sig_s), .sig1(sig1_s),
    .dump_ready(ready_s), .tx_en(tx_en_s), .sample(sample_s), .sample_stb(sample_stb_s),
    .busy(busy_s), .done(done_s), .cmd_err(cmd_err_s), .overrun(overrun_s)
  );

  // Expected {tx_en, busy, done, sample_stb} at cycle rel after an accepted start.
  function automatic logic [3:0] exp_flags(input int rel_in, input int p, input logic [7:0] rdy,
                                           input int abort_rel, input bit cont);
    int rel = rel_in;
    int t_last = C0 + (CAP - 1) * p;
    int k;
    logic tx_e, busy_e, done_e, stb_e;
    if (abort_rel > 0 && rel > abort_rel) return 4'b0000;
    if (cont && rel > t_last + 2) rel = rel - (t_last + 2);
    tx_e   = (rel >= 1) && (rel <= TX);
    busy_e = (rel >= 1) && (cont || rel <= t_last + 2);
    done_e = (rel == t_last + 2);
    k      = rel - 1 - C0;
    stb_e  = (k >= 0) && (k % p == 0) && (k / p < CAP) && rdy[k / p];
    return {tx_e, busy_e, done_e, stb_e};
  endfunction

  // Channel pattern driven in cycle rel.
  function automatic logic [1:0] drv(input int rel);
    logic [31:0] r = rel;
    return r[1:0] ^ r[4:3];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_dat = b;
    cmd_stb = 1'b1;
    step();
    cmd_stb = 1'b0;
    cmd_dat = 8'h00;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({tx_en, sample, sample_stb, busy, done, cmd_err, overrun} !== 15'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h exp=0", {tx_en, sample, sample_stb, busy, done, cmd_err, overrun});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({tx_en, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_idle got=%b exp=00", {tx_en, busy});
    end
  endtask

  task automatic test_single();
    int n_tx = 0, n_stb = 0;
    logic [3:0] got, exp;
    send_cmd(8'h53);
    for (int rel = 1; rel <= 30; rel++) begin
      got = {tx_en, busy, done, sample_stb};
      exp = exp_flags(rel, 1, 8'hFF, 0, 1'b0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL single_flags rel=%0d got=%b exp=%b", rel, got, exp);
      end
      if (exp[0]) begin
        n_checks++;
        if (sample !== drv(rel - 1)) begin
          n_errors++;
          $display("FAIL single_sample rel=%0d got=%b exp=%b", rel, sample, drv(rel - 1));
        end
      end
      if (cmd_err !== 1'b0) begin
        n_errors++;
        $display("FAIL single_cmd_err rel=%0d got=1 exp=0", rel);
      end
      n_tx  += int'(tx_en);
      n_stb += int'(sample_stb);
      {sig1, sig} = drv(rel);
      step();
    end
    n_checks++;
    if (n_tx != TX || n_stb != CAP || overrun !== 8'd0) begin
      n_errors++;
      $display("FAIL single_totals got tx=%0d stb=%0d ovr=%0d exp tx=%0d stb=%0d ovr=0",
               n_tx, n_stb, overrun, TX, CAP);
    end
  endtask

  task automatic test_decim();
    logic [3:0] got, exp;
    send_cmd(8'h32);
    send_cmd(8'h53);
    for (int rel = 1; rel <= 50; rel++) begin
      got = {tx_en, busy, done, sample_stb};
      exp = exp_flags(rel, 4, 8'hFF, 0, 1'b0);
      n_checks++;
      if (got !== exp || cmd_err !== 1'b0) begin
        n_errors++;
        $display("FAIL decim_flags rel=%0d got=%b err=%b exp=%b err=0", rel, got, cmd_err, exp);
      end
      if (exp[0] && sample !== drv(rel - 1)) begin
        n_errors++;
        $display("FAIL decim_sample rel=%0d got=%b exp=%b", rel, sample, drv(rel - 1));
      end
      {sig1, sig} = drv(rel);
      cmd_stb = (rel == 25);
      cmd_dat = (rel == 25) ? 8'h30 : 8'h00;
      step();
    end
  endtask

  task automatic test_overrun();
    logic [3:0] got, exp;
    send_cmd(8'h53);
    for (int rel = 1; rel <= 30; rel++) begin
      got = {tx_en, busy, done, sample_stb};
      exp = exp_flags(rel, 1, 8'b1100_1011, 0, 1'b0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL overrun_flags rel=%0d got=%b exp=%b", rel, got, exp);
      end
      {sig1, sig} = drv(rel);
      dump_ready = !(rel == C0 + 2 || rel == C0 + 4 || rel == C0 + 5);
      step();
    end
    dump_ready = 1'b1;
    n_checks++;
    if (overrun !== 8'd3) begin
      n_errors++;
      $display("FAIL overrun_count got=%0d exp=3", overrun);
    end
  endtask

  task automatic test_saturate();
    int done_rel = -1, n_stb = 0;
    cmd_dat_s = 8'h53;
    cmd_stb_s = 1'b1;
    step();
    cmd_stb_s = 1'b0;
    for (int rel = 1; rel <= 330; rel++) begin
      if (done_s && done_rel < 0) done_rel = rel;
      n_stb += int'(sample_stb_s);
      step();
    end
    n_checks++;
    if (done_rel != C0 + 299 + 2 || n_stb != 0) begin
      n_errors++;
      $display("FAIL sat_done got rel=%0d stb=%0d exp rel=%0d stb=0", done_rel, n_stb, C0 + 301);
    end
    n_checks++;
    if (overrun_s !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_overrun got=%0d exp=255", overrun_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    send_cmd(8'h43);
    for (int rel = 1; rel <= 45; rel++) begin
      got = {tx_en, busy, done, sample_stb};
      exp = exp_flags(rel, 1, 8'hFF, 30, 1'b1);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL b2b_flags rel=%0d got=%b exp=%b", rel, got, exp);
      end
      {sig1, sig} = drv(rel);
      cmd_stb = (rel == 30);
      cmd_dat = (rel == 30) ? 8'h58 : 8'h00;
      step();
    end
  endtask

  task automatic test_cmd_err();
    logic [3:0] got, exp;
    logic err_exp;
    send_cmd(8'h53);
    for (int rel = 1; rel <= 30; rel++) begin
      got = {tx_en, busy, done, sample_stb};
      exp = exp_flags(rel, 1, 8'hFF, 0, 1'b0);
      err_exp = (rel == 6) || (rel == 9);
      n_checks++;
      if (got !== exp || cmd_err !== err_exp) begin
        n_errors++;
        $display("FAIL cmd_err rel=%0d got=%b err=%b exp=%b err=%b", rel, got, cmd_err, exp, err_exp);
      end
      {sig1, sig} = drv(rel);
      cmd_stb = (rel == 5) || (rel == 8);
      cmd_dat = (rel == 5) ? 8'h53 : (rel == 8) ? 8'h41 : 8'h00;
      step();
    end
  endtask

  task automatic test_async_reset();
    send_cmd(8'h53);
    for (int rel = 1; rel < C0 + 4; rel++) begin
      {sig1, sig} = 2'b11;
      step();
    end
    n_checks++;
    if (busy !== 1'b1 || sample !== 2'b11) begin
      n_errors++;
      $display("FAIL pre_reset got busy=%b sample=%b exp busy=1 sample=11", busy, sample);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_en, sample, sample_stb, busy, done, cmd_err, overrun} !== 15'd0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=0", {tx_en, sample, sample_stb, busy, done, cmd_err, overrun});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if ({tx_en, busy, sample_stb} !== 3'b000) begin
      n_errors++;
      $display("FAIL post_reset_idle got=%b exp=000", {tx_en, busy, sample_stb});
    end
    send_cmd(8'h53);
    n_checks++;
    if ({tx_en, busy, cmd_err} !== 3'b110) begin
      n_errors++;
      $display("FAIL post_reset_start got=%b exp=110", {tx_en, busy, cmd_err});
    end
    send_cmd(8'h58);
  endtask

  initial begin
    test_reset();
    test_single();
    test_decim();
    test_overrun();
    test_saturate();
    test_back_to_back();
    test_cmd_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
